// File: rtl/operand_serializer.sv
// ---------------------------------------------------------------------------
// operand_serializer
//
// Upstream feeder for a bit-serial adder. It accepts a pair of parallel
// WIDTH-bit operands over a valid/ready handshake and shifts them out
// LSB-first, one bit pair per clock. A one-entry pending register accepts
// the next pair while the current word is still shifting, so consecutive
// words stream out with no idle cycle in between. The first_bit and
// last_bit strobes frame each word so the adder can clear its carry.
//
// Ports:
//   clk        rising-edge clock, shared with the serial adder
//   rst        synchronous, active-high reset
//   load_valid op_a/op_b hold a valid operand pair
//   load_ready serializer can accept a pair this cycle (= !pend_full)
//   op_a/op_b  parallel operands, sampled only on a transfer cycle
//   out_A/B    serial operand bits, LSB first (to adder in_A/in_B)
//   first_bit  high while bit 0 of a word is on out_A/out_B
//   last_bit   high while bit WIDTH-1 of a word is on out_A/out_B
//   busy       a word is currently being shifted out
// ---------------------------------------------------------------------------
module operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_A,
    output logic             out_B,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_a_q, pend_a_d;
    logic [WIDTH-1:0] pend_b_q, pend_b_d;
    logic             pend_full_q, pend_full_d;

    logic             xfer;

    // Ready depends on state only, never on load_valid.
    assign xfer = load_valid && !pend_full_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cnt_q       <= '0;
            pend_a_q    <= '0;
            pend_b_q    <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            cnt_q       <= cnt_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        cnt_d       = cnt_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        pend_full_d = pend_full_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sh_a_d = sh_a_q >> 1;
                    sh_b_d = sh_b_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (xfer) begin
                        pend_a_d    = op_a;
                        pend_b_d    = op_b;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    // End of word: the pending entry wins. No transfer can
                    // coincide because load_ready is low while it is full.
                    sh_a_d      = pend_a_q;
                    sh_b_d      = pend_b_q;
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (xfer) begin
                    // End of word with an empty pending slot: bypass it.
                    sh_a_d = op_a;
                    sh_b_d = op_b;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: functions of registered state only
    always_comb begin
        busy       = (state_q == SHIFT);
        load_ready = !pend_full_q;
        out_A      = busy && sh_a_q[0];
        out_B      = busy && sh_b_q[0];
        first_bit  = busy && (cnt_q == '0);
        last_bit   = busy && (cnt_q == CNT_LAST);
    end

endmodule

// File: tb/tb_operand_serializer.sv
module tb_operand_serializer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    logic         lv4, lr4, oa4, ob4, fb4, lb4, bs4;
    logic [W-1:0] a4, b4;

    logic         lv8, lr8, oa8, ob8, fb8, lb8, bs8;
    logic [7:0]   a8, b8;

    always #5 clk = ~clk;

    operand_serializer #(.WIDTH(W)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(lr4),
        .op_a(a4), .op_b(b4), .out_A(oa4), .out_B(ob4),
        .first_bit(fb4), .last_bit(lb4), .busy(bs4)
    );

    operand_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(lr8),
        .op_a(a8), .op_b(b8), .out_A(oa8), .out_B(ob8),
        .first_bit(fb8), .last_bit(lb8), .busy(bs8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of words in flight (front = shifting word)
    // and the index of the bit currently presented.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t q[$];
    int    idx      = 0;
    bit    model_ok = 0;

    // Serial adder fed from observed DUT outputs
    logic         carry;
    logic [W-1:0] ssum;

    int busy_run = 0;
    int max_run  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the WIDTH=4 DUT: drive inputs, check outputs against the
    // model, advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic r, output bit xfer);
        bit     eb;
        logic   ea, ebb;
        logic [W:0] exp_sum;
        lv4 = v; a4 = a; b4 = b; rst = r;
        eb = (q.size() > 0);
        if (model_ok) begin
            ea  = eb ? q[0].a[idx] : 1'b0;
            ebb = eb ? q[0].b[idx] : 1'b0;
            chk("busy",       32'(bs4), 32'(eb));
            chk("load_ready", 32'(lr4), 32'(q.size() < 2));
            chk("out_A",      32'(oa4), 32'(ea));
            chk("out_B",      32'(ob4), 32'(ebb));
            chk("first_bit",  32'(fb4), 32'(eb && idx == 0));
            chk("last_bit",   32'(lb4), 32'(eb && idx == W - 1));
            if (eb) begin
                if (idx == 0) carry = 1'b0;
                ssum[idx] = oa4 ^ ob4 ^ carry;
                carry     = (oa4 & ob4) | (oa4 & carry) | (ob4 & carry);
                if (idx == W - 1) begin
                    exp_sum = {1'b0, q[0].a} + {1'b0, q[0].b};
                    chk("serial_sum", 32'({carry, ssum}), 32'(exp_sum));
                end
            end
        end
        if (bs4 === 1'b1) begin
            busy_run++;
            if (busy_run > max_run) max_run = busy_run;
        end else begin
            busy_run = 0;
        end
        xfer = !r && v && (q.size() < 2);
        @(posedge clk);
        if (r) begin
            q.delete();
            idx      = 0;
            model_ok = 1;
        end else begin
            if (q.size() > 0) begin
                idx++;
                if (idx == W) begin
                    void'(q.pop_front());
                    idx = 0;
                end
            end
            if (xfer) q.push_back('{a, b});
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit x;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, x);
    endtask

    initial begin
        bit           x;
        int           k;
        int           guard;
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];
        logic         c8;
        logic [7:0]   s8;

        lv4 = 0; a4 = '0; b4 = '0; rst = 1;
        lv8 = 0; a8 = '0; b8 = '0;
        carry = 0; ssum = '0;

        // Reset, with load_valid asserted to show it is ignored
        cycle(1'b1, 4'hF, 4'hF, 1'b1, x);
        cycle(1'b1, 4'hF, 4'hF, 1'b1, x);
        chk("reset_busy",  32'(bs4), 32'd0);
        chk("reset_ready", 32'(lr4), 32'd1);
        chk("reset_outA",  32'(oa4), 32'd0);
        idle(1);

        // Single word 0110 / 0011 -> sum 9
        cycle(1'b1, 4'b0110, 4'b0011, 1'b0, x);
        idle(6);

        // Streaming three words with load_valid held high
        pa = '{4'd1, 4'd3, 4'd5};
        pb = '{4'd2, 4'd4, 4'd6};
        max_run = 0;
        k = 0;
        guard = 0;
        while (k < 3 && guard < 50) begin
            cycle(1'b1, pa[k], pb[k], 1'b0, x);
            if (x) k++;
            guard++;
        end
        chk("stream_all_accepted", 32'(k), 32'd3);
        idle(14);
        chk("stream_busy_run", 32'(max_run), 32'd12);

        // Pending-only path: second transfer at cnt=1
        cycle(1'b1, 4'($urandom), 4'($urandom), 1'b0, x);
        idle(1);
        cycle(1'b1, 4'($urandom), 4'($urandom), 1'b0, x);
        chk("pend_ready_low", 32'(lr4), 32'd0);
        idle(10);

        // End-of-word direct load: transfer on the last_bit cycle
        cycle(1'b1, 4'b1010, 4'b0101, 1'b0, x);
        idle(3);
        chk("eow_last_bit", 32'(lb4), 32'd1);
        cycle(1'b1, 4'b0011, 4'b1001, 1'b0, x);
        chk("eow_first_bit", 32'(fb4), 32'd1);
        chk("eow_ready",     32'(lr4), 32'd1);
        idle(5);

        // Reset at cnt=2 with a pending word held
        cycle(1'b1, 4'b1111, 4'b1111, 1'b0, x);
        idle(1);
        cycle(1'b1, 4'b0111, 4'b0001, 1'b0, x);
        cycle(1'b1, 4'b1100, 4'b1100, 1'b1, x);
        chk("rst_mid_busy",  32'(bs4), 32'd0);
        chk("rst_mid_ready", 32'(lr4), 32'd1);
        chk("rst_mid_outs",  32'({oa4, ob4, fb4, lb4}), 32'd0);
        cycle(1'b1, 4'b1001, 4'b0110, 1'b0, x);
        idle(6);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 39) == 0), x);
        end
        idle(10);

        // WIDTH=8: FF + 01 -> sum 0x00, carry 1
        lv8 = 1; a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk); #1;
        lv8 = 0; a8 = 8'h00; b8 = 8'h00;
        c8 = 0; s8 = '0;
        for (int i = 0; i < 8; i++) begin
            chk("w8_busy",  32'(bs8), 32'd1);
            chk("w8_outA",  32'(oa8), 32'd1);
            chk("w8_outB",  32'(ob8), 32'(i == 0));
            chk("w8_first", 32'(fb8), 32'(i == 0));
            chk("w8_last",  32'(lb8), 32'(i == 7));
            s8[i] = oa8 ^ ob8 ^ c8;
            c8    = (oa8 & ob8) | (oa8 & c8) | (ob8 & c8);
            @(posedge clk); #1;
        end
        chk("w8_sum",   32'(s8), 32'h00);
        chk("w8_carry", 32'(c8), 32'd1);
        chk("w8_idle",  32'(bs8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
